// File: rtl/noc_egress_checker.sv
// NoC egress sink: checks head/tail framing and ingress consistency, counts packets,
// tracks worst head latency and optionally applies LFSR-driven backpressure.
module noc_egress_checker #(
   parameter int unsigned EGRESS_ID        = 0,
   parameter int unsigned NUM_INGRESSES    = 4,
   parameter int unsigned INGRESS_BITS     = 64,
   parameter int unsigned CYCLE_COUNT_BITS = 64,
   parameter int unsigned PAYLOAD_BITS     = 64,
   parameter int unsigned EXPECTED_PACKETS = 16,
   parameter int unsigned MAX_PKT_FLITS    = 8,
   parameter int unsigned TIMEOUT_CYCLES   = 1024,
   parameter int unsigned BP_MODE          = 0,
   parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [CYCLE_COUNT_BITS-1:0] cycle_count,
   input  logic                        noc_valid,
   input  logic                        flit_in_head,
   input  logic                        flit_in_tail,
   input  logic [INGRESS_BITS-1:0]     flit_in_ingress_id,
   input  logic [PAYLOAD_BITS-1:0]     flit_in_payload,
   output logic                        egressunit_ready,
   output logic                        success,
   output logic                        error,
   output logic [2:0]                  error_code,
   output logic [31:0]                 packets_received,
   output logic [CYCLE_COUNT_BITS-1:0] max_latency
);

   localparam int unsigned IdxW = (NUM_INGRESSES > 1) ? $clog2(NUM_INGRESSES) : 1;
   localparam logic [15:0] SeedX = LFSR_SEED ^ 16'(EGRESS_ID);
   localparam logic [15:0] SeedInit = (SeedX == 16'h0) ? 16'h1 : SeedX;
   localparam logic [INGRESS_BITS-1:0] NumIds = INGRESS_BITS'(NUM_INGRESSES);

   typedef enum logic [1:0] {StIdle, StInPkt, StDone, StError} state_e;

   state_e                      state_q, state_d;
   logic [15:0]                 lfsr_q, lfsr_d;
   logic                        ready_q, ready_d;
   logic                        success_q, success_d;
   logic                        error_q, error_d;
   logic [2:0]                  code_q, code_d;
   logic [31:0]                 pkts_q, pkts_d;
   logic [CYCLE_COUNT_BITS-1:0] max_lat_q, max_lat_d;
   logic [INGRESS_BITS-1:0]     id_q, id_d;
   logic [31:0]                 flit_cnt_q, flit_cnt_d;
   logic [31:0]                 idle_q, idle_d;
   logic [31:0]                 ing_cnt_q [NUM_INGRESSES];
   logic [31:0]                 ing_cnt_d [NUM_INGRESSES];

   logic                        accept;
   logic                        head_bad;
   logic                        complete;
   logic [2:0]                  err;
   logic [IdxW-1:0]             idx;
   logic [CYCLE_COUNT_BITS-1:0] latency;
   logic                        unused_payload;

   assign unused_payload = ^flit_in_payload;
   assign accept   = noc_valid & ready_q;
   assign head_bad = flit_in_head && (flit_in_ingress_id >= NumIds);
   assign idx      = flit_in_ingress_id[IdxW-1:0];
   // Modular subtraction keeps latency correct across cycle_count wrap.
   assign latency  = cycle_count - flit_in_payload[CYCLE_COUNT_BITS-1:0];

   always_comb begin
      state_d    = state_q;
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      success_d  = success_q;
      error_d    = error_q;
      code_d     = code_q;
      pkts_d     = pkts_q;
      max_lat_d  = max_lat_q;
      id_d       = id_q;
      flit_cnt_d = flit_cnt_q;
      idle_d     = idle_q;
      ing_cnt_d  = ing_cnt_q;
      complete   = 1'b0;
      err        = 3'd0;

      unique case (state_q)
         StIdle, StInPkt: begin
            idle_d = accept ? 32'd0 : idle_q + 32'd1;
            if (accept) begin
               if (head_bad)                                    err = 3'd5;
               else if (state_q == StInPkt && flit_in_head)     err = 3'd2;
               else if (state_q == StIdle && !flit_in_head)     err = 3'd1;
               else if (state_q == StInPkt && flit_in_ingress_id != id_q) err = 3'd3;
               else if (state_q == StInPkt && (flit_cnt_q + 32'd1) > MAX_PKT_FLITS) err = 3'd4;
            end else if (idle_d >= TIMEOUT_CYCLES) begin
               err = 3'd7;
            end

            if (accept && err == 3'd0) begin
               if (flit_in_head && latency > max_lat_q) max_lat_d = latency;
               if (state_q == StIdle) begin
                  if (flit_in_tail) begin
                     complete = 1'b1;
                  end else begin
                     state_d    = StInPkt;
                     id_d       = flit_in_ingress_id;
                     flit_cnt_d = 32'd1;
                  end
               end else begin
                  flit_cnt_d = flit_cnt_q + 32'd1;
                  if (flit_in_tail) begin
                     complete = 1'b1;
                     state_d  = StIdle;
                  end
               end
            end

            if (complete) begin
               pkts_d = pkts_q + 32'd1;
               ing_cnt_d[idx] = ing_cnt_q[idx] + 32'd1;
               if (pkts_d == 32'(EXPECTED_PACKETS)) begin
                  state_d   = StDone;
                  success_d = 1'b1;
               end
            end
         end
         StDone: begin
            if (accept) begin
               err       = 3'd6;
               success_d = 1'b0;
            end
         end
         StError: ;
         default: ;
      endcase

      if (err != 3'd0) begin
         state_d = StError;
         error_d = 1'b1;
         code_d  = err;
      end

      if (state_d == StError || BP_MODE == 0) ready_d = 1'b1;
      else                                    ready_d = lfsr_d[0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         lfsr_q     <= SeedInit;
         ready_q    <= 1'b0;
         success_q  <= 1'b0;
         error_q    <= 1'b0;
         code_q     <= 3'd0;
         pkts_q     <= 32'd0;
         max_lat_q  <= '0;
         id_q       <= '0;
         flit_cnt_q <= 32'd0;
         idle_q     <= 32'd0;
         for (int i = 0; i < NUM_INGRESSES; i++) ing_cnt_q[i] <= 32'd0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         ready_q    <= ready_d;
         success_q  <= success_d;
         error_q    <= error_d;
         code_q     <= code_d;
         pkts_q     <= pkts_d;
         max_lat_q  <= max_lat_d;
         id_q       <= id_d;
         flit_cnt_q <= flit_cnt_d;
         idle_q     <= idle_d;
         ing_cnt_q  <= ing_cnt_d;
      end
   end

   assign egressunit_ready = ready_q;
   assign success          = success_q;
   assign error            = error_q;
   assign error_code       = code_q;
   assign packets_received = pkts_q;
   assign max_latency      = max_lat_q;

endmodule

// File: tb/tb_noc_egress_checker.sv
// Bench for noc_egress_checker: directed framing/error tests on an always-ready instance and
// a randomized backpressure run on an LFSR-ready instance against a reference model.
module tb_noc_egress_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] cc  = 64'hFFFF_FFFF_FFFF_FF00;

   always #5 clk = ~clk;
   always @(posedge clk) cc <= cc + 64'd1;

   // Instance 0: always ready
   logic        v0 = 1'b0, h0 = 1'b0, t0 = 1'b0;
   logic [63:0] id0 = '0, pay0 = '0;
   logic        rdy0, succ0, err0;
   logic [2:0]  code0;
   logic [31:0] pk0;
   logic [63:0] ml0;

   // Instance 1: LFSR backpressure, one-flit packets only
   logic        v1 = 1'b0;
   logic        one1 = 1'b1;
   logic [63:0] id1 = '0, pay1 = '0;
   logic        rdy1, succ1, err1;
   logic [2:0]  code1;
   logic [31:0] pk1;
   logic [63:0] ml1;

   noc_egress_checker u0 (
      .clock(clk), .reset(rst), .cycle_count(cc), .noc_valid(v0),
      .flit_in_head(h0), .flit_in_tail(t0), .flit_in_ingress_id(id0), .flit_in_payload(pay0),
      .egressunit_ready(rdy0), .success(succ0), .error(err0), .error_code(code0),
      .packets_received(pk0), .max_latency(ml0)
   );

   noc_egress_checker #(.EGRESS_ID(3), .BP_MODE(1), .EXPECTED_PACKETS(100000)) u1 (
      .clock(clk), .reset(rst), .cycle_count(cc), .noc_valid(v1),
      .flit_in_head(one1), .flit_in_tail(one1), .flit_in_ingress_id(id1), .flit_in_payload(pay1),
      .egressunit_ready(rdy1), .success(succ1), .error(err1), .error_code(code1),
      .packets_received(pk1), .max_latency(ml1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic fb;
      fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
      return {s[14:0], fb};
   endfunction

   // Called at a negedge; returns at the following negedge with the flit's effects visible.
   task automatic send0(input logic h, input logic t, input logic [63:0] id, input logic [63:0] lat);
      v0 = 1'b1; h0 = h; t0 = t; id0 = id; pay0 = cc - lat;
      @(posedge clk);
      @(negedge clk);
      v0 = 1'b0; h0 = 1'b0; t0 = 1'b0;
   endtask

   task automatic do_reset();
      v0 = 1'b0; v1 = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   logic [15:0] mlfsr;
   logic        mready;
   int unsigned macc;
   logic [63:0] mmax;
   logic [63:0] lat;

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_ready", {63'd0, rdy0}, 64'd0);
      chk("reset_success", {63'd0, succ0}, 64'd0);
      chk("reset_error", {63'd0, err0}, 64'd0);
      chk("reset_code", {61'd0, code0}, 64'd0);
      chk("reset_pkts", {32'd0, pk0}, 64'd0);
      chk("reset_maxlat", ml0, 64'd0);
      chk("reset_ready_bp", {63'd0, rdy1}, 64'd0);

      // Randomized backpressure run on u1, starting right at the reset release edge.
      rst = 1'b0;
      mlfsr  = 16'hACE1 ^ 16'd3;
      if (mlfsr == 16'h0) mlfsr = 16'h1;
      mready = 1'b0;
      macc   = 0;
      mmax   = '0;
      for (int i = 0; i < 1000; i++) begin
         lat  = 64'($urandom_range(0, 40));
         v1   = 1'b1;
         id1  = 64'($urandom_range(0, 3));
         pay1 = cc - lat;
         if (mready) begin
            macc++;
            if (lat > mmax) mmax = lat;
         end
         @(posedge clk);
         #1;
         mlfsr  = lfsr_next(mlfsr);
         mready = mlfsr[0];
         chk("bp_ready", {63'd0, rdy1}, {63'd0, mready});
         @(negedge clk);
      end
      v1 = 1'b0;
      chk("bp_accepted", {32'd0, pk1}, 64'(macc));
      chk("bp_maxlat", ml1, mmax);
      chk("bp_error", {63'd0, err1}, 64'd0);

      // Sixteen one-flit packets, latency 5, random ingress ids.
      do_reset();
      chk("ready_after_reset", {63'd0, rdy0}, 64'd1);
      for (int i = 0; i < 16; i++) begin
         send0(1'b1, 1'b1, 64'($urandom_range(0, 3)), 64'd5);
         if (i == 14) chk("success_early", {63'd0, succ0}, 64'd0);
      end
      chk("t1_success", {63'd0, succ0}, 64'd1);
      chk("t1_pkts", {32'd0, pk0}, 64'd16);
      chk("t1_maxlat", ml0, 64'd5);
      chk("t1_error", {63'd0, err0}, 64'd0);
      send0(1'b1, 1'b1, 64'd0, 64'd5);
      chk("extra_success", {63'd0, succ0}, 64'd0);
      chk("extra_code", {61'd0, code0}, 64'd6);
      chk("extra_error", {63'd0, err0}, 64'd1);

      // Ingress id change inside a packet.
      do_reset();
      send0(1'b1, 1'b0, 64'd1, 64'd2);
      send0(1'b0, 1'b0, 64'd2, 64'd0);
      chk("t2_error", {63'd0, err0}, 64'd1);
      chk("t2_code", {61'd0, code0}, 64'd3);
      chk("t2_ready", {63'd0, rdy0}, 64'd1);
      send0(1'b0, 1'b1, 64'd1, 64'd0);
      chk("t2_code_held", {61'd0, code0}, 64'd3);

      do_reset();
      send0(1'b0, 1'b1, 64'd0, 64'd0);
      chk("orphan_code", {61'd0, code0}, 64'd1);

      do_reset();
      send0(1'b1, 1'b0, 64'd0, 64'd0);
      send0(1'b1, 1'b0, 64'd0, 64'd0);
      chk("head_in_pkt_code", {61'd0, code0}, 64'd2);

      do_reset();
      send0(1'b1, 1'b0, 64'd0, 64'd0);
      send0(1'b1, 1'b1, 64'd7, 64'd0);
      chk("prio_bad_id_code", {61'd0, code0}, 64'd5);

      // 8-flit packet is legal, 9-flit packet trips the length check on its 9th flit.
      do_reset();
      send0(1'b1, 1'b0, 64'd2, 64'd3);
      for (int i = 0; i < 6; i++) send0(1'b0, 1'b0, 64'd2, 64'd0);
      send0(1'b0, 1'b1, 64'd2, 64'd0);
      chk("len8_pkts", {32'd0, pk0}, 64'd1);
      chk("len8_error", {63'd0, err0}, 64'd0);
      send0(1'b1, 1'b0, 64'd3, 64'd0);
      for (int i = 0; i < 7; i++) send0(1'b0, 1'b0, 64'd3, 64'd0);
      chk("len9_pre_error", {63'd0, err0}, 64'd0);
      send0(1'b0, 1'b1, 64'd3, 64'd0);
      chk("len9_code", {61'd0, code0}, 64'd4);

      // Asynchronous reset in the middle of a packet.
      do_reset();
      send0(1'b1, 1'b1, 64'd0, 64'd1);
      send0(1'b1, 1'b1, 64'd1, 64'd9);
      send0(1'b1, 1'b1, 64'd2, 64'd4);
      send0(1'b1, 1'b0, 64'd3, 64'd2);
      chk("pre_abort_pkts", {32'd0, pk0}, 64'd3);
      chk("pre_abort_maxlat", ml0, 64'd9);
      #2 rst = 1'b1;
      #1;
      chk("abort_pkts", {32'd0, pk0}, 64'd0);
      chk("abort_maxlat", ml0, 64'd0);
      chk("abort_ready", {63'd0, rdy0}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send0(1'b1, 1'b1, 64'd1, 64'd0);
      chk("post_abort_pkts", {32'd0, pk0}, 64'd1);
      chk("post_abort_error", {63'd0, err0}, 64'd0);

      // Idle timeout.
      do_reset();
      repeat (1015) @(negedge clk);
      chk("timeout_early", {63'd0, err0}, 64'd0);
      repeat (20) @(negedge clk);
      chk("timeout_code", {61'd0, code0}, 64'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
